ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_pkg.sv | 22 ++
 rtl/ex_muldiv.sv | 150 +++++++++++++++
 tb/tb_ex_muldiv.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared pipeline definitions for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int ITER_DEF  = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage; results are written to HI/LO.
// Latency: ITER+1 cycles from the accept edge to done_o (ITER CALC cycles, then one DONE cycle).
// Backpressure: stall_o holds PC, IF/ID and ID/EX from the request cycle through CALC; it is low in DONE.
// Ports: clk_i/rst_n_i clock and async active-low reset; start_i/op_i/rsdata_i/rtdata_i request;
//        flush_i aborts; stall_o/busy_o/done_o status; hi_o/lo_o results; div_zero_o divisor-0 flag.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITER  = ITER_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rsdata_i,
    input  logic [WIDTH-1:0] rtdata_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(ITER + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    op_e                op_q;
    logic               sign_a_q, sign_b_q;
    logic [WIDTH-1:0]   opnd_q;      // multiplicand (mul) or divisor (div) magnitude
    logic [2*WIDTH:0]   acc_q;       // mul: {0, product}; div: {partial remainder, dividend/quotient}
    logic [WIDTH-1:0]   hi_q, lo_q;

    // ---------------- request decode ----------------
    op_e              op_in;
    logic             in_signed, in_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept, last_iter, commit, is_div_q;

    assign op_in     = op_e'(op_i);
    assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign in_div    = (op_in == OP_DIV)  || (op_in == OP_DIVU);
    assign a_neg     = in_signed & rsdata_i[WIDTH-1];
    assign b_neg     = in_signed & rtdata_i[WIDTH-1];
    // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
    assign a_mag     = a_neg ? -rsdata_i : rsdata_i;
    assign b_mag     = b_neg ? -rtdata_i : rtdata_i;

    assign is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign accept    = (state_q == ST_IDLE) && start_i && !flush_i;
    assign last_iter = (cnt_q == CW'(ITER - 1));
    assign commit    = (state_q == ST_DONE) && !flush_i;

    // ---------------- one iteration step ----------------
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] mul_next, div_next;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH:0]   div_part, div_rem;
    logic             div_ok;

    // shift-add: add multiplicand to the upper half when the current multiplier bit is set, then shift right
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

    // restoring divide: shift the next dividend bit into the remainder and try a subtract;
    // a borrow means the remainder is kept and the quotient bit is 0
    assign div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = {acc_q[2*WIDTH], div_part} - {2'b00, opnd_q};
    assign div_ok   = ~div_diff[WIDTH+1];
    assign div_rem  = div_ok ? div_diff[WIDTH:0] : div_part;
    assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ok};

    // ---------------- sign fix / result select ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;
    logic               neg_res, div_zero;

    assign neg_res  = sign_a_q ^ sign_b_q;
    assign prod_fix = neg_res  ? -acc_q[2*WIDTH-1:0]     : acc_q[2*WIDTH-1:0];
    assign quot_fix = neg_res  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
    assign rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    // with a zero divisor every trial subtract succeeds, so the remainder ends up as the
    // dividend magnitude and rem_fix restores the raw dividend; only LO needs overriding
    assign div_zero = is_div_q && (opnd_q == '0);
    assign res_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = is_div_q ? (div_zero ? '1 : quot_fix) : prod_fix[WIDTH-1:0];

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_CALC;
            ST_CALC: begin
                if (flush_i)        state_d = ST_IDLE;
                else if (last_iter) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (accept) begin
                cnt_q    <= '0;
                op_q     <= op_in;
                sign_a_q <= a_neg;
                sign_b_q <= b_neg;
                opnd_q   <= in_div ? b_mag : a_mag;
                acc_q    <= {{(WIDTH+1){1'b0}}, (in_div ? a_mag : b_mag)};
            end else if (state_q == ST_CALC) begin
                cnt_q    <= cnt_q + CW'(1);
                acc_q    <= is_div_q ? div_next : mul_next;
            end
            if (commit) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    // ---------------- outputs ----------------
    // stall is gated by reset so the pipeline is never held while the unit is in reset
    assign stall_o    = rst_n_i && (accept || (state_q == ST_CALC));
    assign busy_o     = (state_q == ST_CALC) || (state_q == ST_DONE);
    assign done_o     = commit;
    assign div_zero_o = commit && div_zero;
    // the committed result is visible in the same cycle as done_o
    assign hi_o       = commit ? res_hi : hi_q;
    assign lo_o       = commit ? res_lo : lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random operations vs. an arithmetic model.
// Latency: checks done_o exactly 33 cycles after the request cycle.
// Backpressure: checks stall_o/busy_o through request, CALC, DONE, flush and reset.
module tb_ex_muldiv;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rsdata_i;
    logic [31:0] rtdata_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_zero_o;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] last_hi  = 32'h0;
    logic [31:0] last_lo  = 32'h0;

    ex_muldiv dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .rsdata_i   (rsdata_i),
        .rtdata_i   (rtdata_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic with the architectural corner cases.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint      p;
        logic [63:0] u;
        dz = 1'b0;
        hi = 32'h0;
        lo = 32'h0;
        case (op)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {hi, lo} = p;
            end
            2'b01: begin
                u = {32'h0, a} * {32'h0, b};
                {hi, lo} = u;
            end
            2'b10: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF; hi = a; dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'h0;
                end else begin
                    lo = $signed(a) / $signed(b);
                    hi = $signed(a) % $signed(b);
                end
            end
            default: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF; hi = a; dz = 1'b1;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Called in the request cycle (start_i already driven). Returns in the DONE cycle.
    task automatic finish_op(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo,
                             input logic e_dz, input bit junk);
        int cyc;
        int stall_bad;
        #1;
        chk({tag, "_stall_req"}, stall_o, 1);
        @(negedge clk_i);
        cyc = 1;
        stall_bad = 0;
        while (!done_o && cyc < 100) begin
            if (!stall_o || !busy_o) stall_bad++;
            if (junk) begin
                start_i  = 1'($urandom_range(0, 1));
                op_i     = 2'($urandom_range(0, 3));
                rsdata_i = $urandom;
                rtdata_i = $urandom;
            end
            @(negedge clk_i);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 33);
        chk({tag, "_stall_calc"}, stall_bad, 0);
        chk({tag, "_hi"}, hi_o, e_hi);
        chk({tag, "_lo"}, lo_o, e_lo);
        chk({tag, "_dz"}, div_zero_o, e_dz);
        chk({tag, "_done_stall"}, stall_o, 0);
        chk({tag, "_done_busy"}, busy_o, 1);
        last_hi = e_hi;
        last_lo = e_lo;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input logic e_dz);
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; rsdata_i = a; rtdata_i = b;
        finish_op(tag, e_hi, e_lo, e_dz, 1'b1);
        start_i = 1'b0;
        @(negedge clk_i);
        chk({tag, "_pulse"}, done_o, 0);
        chk({tag, "_hold_hi"}, hi_o, last_hi);
        chk({tag, "_hold_lo"}, lo_o, last_lo);
        chk({tag, "_idle_busy"}, busy_o, 0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'($urandom_range(0, 15));
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [1:0]  op, op2;
        logic [31:0] a, b, a2, b2, e_hi, e_lo, e_hi2, e_lo2;
        logic        e_dz, e_dz2;
        int          nd;

        // ---- reset state (start_i high must not raise stall_o) ----
        rst_n_i = 1'b0; start_i = 1'b1; flush_i = 1'b0; op_i = 2'b00;
        rsdata_i = 32'h0; rtdata_i = 32'h0;
        #2;
        chk("rst_stall", stall_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_hilo", {hi_o, lo_o}, 64'h0);
        @(negedge clk_i);
        start_i = 1'b0;
        rst_n_i = 1'b1;

        // ---- directed corner cases ----
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_zero", 2'b11, 32'h7,         32'h0,         32'h7,         32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0);
        run_op("div_zero",  2'b10, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

        // ---- random operations ----
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = rnd_operand();
            b  = rnd_operand();
            model(op, a, b, e_hi, e_lo, e_dz);
            run_op($sformatf("rnd%0d", i), op, a, b, e_hi, e_lo, e_dz);
        end

        // ---- flush at CALC cycle 10 ----
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b00; rsdata_i = 32'h1234_5678; rtdata_i = 32'h9ABC_DEF0;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush_calc_busy", busy_o, 0);
        chk("flush_calc_hi", hi_o, last_hi);
        chk("flush_calc_lo", lo_o, last_lo);
        nd = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o) nd++;
        end
        chk("flush_calc_nodone", nd, 0);
        chk("flush_calc_hold", {hi_o, lo_o}, {last_hi, last_lo});

        // ---- flush in DONE ----
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b01; rsdata_i = 32'h0000_1000; rtdata_i = 32'h0000_0100;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (32) @(negedge clk_i);
        chk("flush_done_pre", done_o, 1);
        flush_i = 1'b1;
        #1;
        chk("flush_done_done", done_o, 0);
        chk("flush_done_hi", hi_o, last_hi);
        chk("flush_done_lo", lo_o, last_lo);
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush_done_busy", busy_o, 0);
        chk("flush_done_hold", {hi_o, lo_o}, {last_hi, last_lo});

        // ---- flush in IDLE blocks a simultaneous start ----
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; rsdata_i = 32'h5; rtdata_i = 32'h5;
        #1;
        chk("flush_idle_stall", stall_o, 0);
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush_idle_busy", busy_o, 0);

        // ---- back-to-back with start_i held high ----
        op = 2'b10; a = 32'hFFFF_FC00; b = 32'h0000_0007;
        op2 = 2'b00; a2 = 32'h0001_0003; b2 = 32'hFFFF_FFF5;
        model(op, a, b, e_hi, e_lo, e_dz);
        model(op2, a2, b2, e_hi2, e_lo2, e_dz2);
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; rsdata_i = a; rtdata_i = b;
        finish_op("b2b_first", e_hi, e_lo, e_dz, 1'b0);
        op_i = op2; rsdata_i = a2; rtdata_i = b2;
        @(negedge clk_i);
        chk("b2b_idle_busy", busy_o, 0);
        finish_op("b2b_second", e_hi2, e_lo2, e_dz2, 1'b0);
        start_i = 1'b0;
        @(negedge clk_i);

        // ---- async reset at CALC cycle 5 ----
        start_i = 1'b1; op_i = 2'b01; rsdata_i = 32'hDEAD_BEEF; rtdata_i = 32'h1111_1111;
        @(negedge clk_i);
        repeat (4) @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        chk("rstc_stall", stall_o, 0);
        chk("rstc_busy", busy_o, 0);
        chk("rstc_done", done_o, 0);
        chk("rstc_dz", div_zero_o, 0);
        chk("rstc_hi", hi_o, 0);
        chk("rstc_lo", lo_o, 0);
        @(negedge clk_i);
        chk("rstc_hold_busy", busy_o, 0);
        // release with a request already waiting: accepted on the first edge
        op = 2'b11; a = 32'h0000_0064; b = 32'h0000_0007;
        model(op, a, b, e_hi, e_lo, e_dz);
        rst_n_i = 1'b1;
        op_i = op; rsdata_i = a; rtdata_i = b;
        finish_op("rst_release", e_hi, e_lo, e_dz, 1'b1);
        start_i = 1'b0;
        @(negedge clk_i);
        chk("rst_release_hold", {hi_o, lo_o}, {last_hi, last_lo});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
